// File: rtl/multi_chan_counter_if.sv
// Command/response bundle for multi_chan_counter: valid/ready command in,
// valid/ready response out, plus the flat view of every counter.
interface multi_chan_counter_if #(
  parameter int N   = 8,
  parameter int CH  = 4,
  parameter int CHW = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [CHW-1:0]  in_ch;
  logic [1:0]      in_op;
  logic [N-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CHW-1:0]  out_ch;
  logic [N-1:0]    out_count;
  logic            out_flag;
  logic            out_err;
  logic [CH*N-1:0] dout;

  modport slave (
    input  in_valid, in_ch, in_op, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_count, out_flag, out_err, dout
  );

  modport master (
    output in_valid, in_ch, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_count, out_flag, out_err, dout
  );
endinterface

// File: rtl/multi_chan_counter.sv
// CH independent N-bit counters driven by LOAD/INC/DEC/CLEAR commands, with a
// single registered response stage per accepted command.
module multi_chan_counter #(
  parameter int N        = 8,
  parameter int CH       = 4,
  parameter int CHW      = 2,
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_chan_counter_if.slave  bus
);
  localparam logic [1:0]   OP_LOAD  = 2'b00;
  localparam logic [1:0]   OP_INC   = 2'b01;
  localparam logic [1:0]   OP_DEC   = 2'b10;
  localparam logic [1:0]   OP_CLEAR = 2'b11;
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CHW:0] CH_LIM   = (CHW+1)'(CH);

  logic [N-1:0]   r_count [CH];
  logic           r_out_valid;
  logic [CHW-1:0] r_out_ch;
  logic [N-1:0]   r_out_count;
  logic           r_out_flag;
  logic           r_out_err;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_err;
  logic [N-1:0]   w_cur;
  logic [N-1:0]   w_next;
  logic           w_flag;
  logic [CH-1:0]  w_we;

  // Ready depends only on the output stage, never on in_valid.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_err      = ({1'b0, bus.in_ch} >= CH_LIM);

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < CH; k++) begin
      if (bus.in_ch == CHW'(k)) w_cur = r_count[k];
    end
  end

  always_comb begin
    w_next = w_cur;
    w_flag = 1'b0;
    case (bus.in_op)
      OP_LOAD:  w_next = bus.in_data;
      OP_CLEAR: w_next = '0;
      OP_INC: begin
        if (w_cur == '1) begin
          w_flag = 1'b1;
          w_next = (SATURATE != 0) ? '1 : '0;
        end else begin
          w_next = w_cur + ONE;
        end
      end
      OP_DEC: begin
        if (w_cur == '0) begin
          w_flag = 1'b1;
          w_next = (SATURATE != 0) ? '0 : '1;
        end else begin
          w_next = w_cur - ONE;
        end
      end
      default: w_next = w_cur;
    endcase
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign w_we[gi] = w_accept && !w_err && (bus.in_ch == CHW'(gi));
      assign bus.dout[gi*N +: N] = r_count[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) r_count[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (w_we[k]) r_count[k] <= w_next;
      end
    end
  end

  // Response fields load only on accept, so they stay frozen under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_count <= '0;
      r_out_flag  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= bus.in_ch;
      r_out_count <= w_err ? '0 : w_next;
      r_out_flag  <= w_err ? 1'b0 : w_flag;
      r_out_err   <= w_err;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_count = r_out_count;
  assign bus.out_flag  = r_out_flag;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_multi_chan_counter.sv
// Drives a wrap-around instance (CH=3) and a saturating instance (CH=4) in
// lockstep and compares both against an arithmetic reference model.
module tb_multi_chan_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_chan_counter_if #(.N(8), .CH(3), .CHW(2)) ifa ();
  multi_chan_counter_if #(.N(8), .CH(4), .CHW(2)) ifb ();

  multi_chan_counter #(.N(8), .CH(3), .CHW(2), .SATURATE(0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  multi_chan_counter #(.N(8), .CH(4), .CHW(2), .SATURATE(1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: index 0 = wrap instance, 1 = saturating instance
  int m_cnt [2][4];
  int e_ch  [2];
  int e_cnt [2];
  int e_flag[2];
  int e_err [2];
  bit e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      e_ch[i] = 0; e_cnt[i] = 0; e_flag[i] = 0; e_err[i] = 0;
    end
    e_valid = 1'b0;
  endtask

  task automatic model_apply(input int inst, input int ch, input int op, input int d);
    int nch;
    int c;
    bit sat;
    nch = (inst == 0) ? 3 : 4;
    sat = (inst == 1);
    e_ch[inst] = ch;
    e_flag[inst] = 0;
    if (ch >= nch) begin
      e_err[inst] = 1;
      e_cnt[inst] = 0;
    end else begin
      e_err[inst] = 0;
      c = m_cnt[inst][ch];
      case (op)
        0: c = d;
        1: if (c == 255) begin e_flag[inst] = 1; c = sat ? 255 : 0; end else c = c + 1;
        2: if (c == 0) begin e_flag[inst] = 1; c = sat ? 0 : 255; end else c = c - 1;
        default: c = 0;
      endcase
      m_cnt[inst][ch] = c;
      e_cnt[inst] = c;
    end
  endtask

  function automatic logic [31:0] exp_dout(input int inst);
    logic [31:0] r;
    int nch;
    r = 0;
    nch = (inst == 0) ? 3 : 4;
    for (int k = 0; k < nch; k++) r = r | (32'(m_cnt[inst][k]) << (8 * k));
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " wrap out_valid"}, 32'(ifa.out_valid), 32'(e_valid));
    chk({tag, " wrap out_ch"},    32'(ifa.out_ch),    32'(e_ch[0]));
    chk({tag, " wrap out_count"}, 32'(ifa.out_count), 32'(e_cnt[0]));
    chk({tag, " wrap out_flag"},  32'(ifa.out_flag),  32'(e_flag[0]));
    chk({tag, " wrap out_err"},   32'(ifa.out_err),   32'(e_err[0]));
    chk({tag, " wrap dout"},      32'(ifa.dout),      exp_dout(0));
    chk({tag, " sat out_valid"},  32'(ifb.out_valid), 32'(e_valid));
    chk({tag, " sat out_ch"},     32'(ifb.out_ch),    32'(e_ch[1]));
    chk({tag, " sat out_count"},  32'(ifb.out_count), 32'(e_cnt[1]));
    chk({tag, " sat out_flag"},   32'(ifb.out_flag),  32'(e_flag[1]));
    chk({tag, " sat out_err"},    32'(ifb.out_err),   32'(e_err[1]));
    chk({tag, " sat dout"},       ifb.dout,           exp_dout(1));
  endtask

  // One clock cycle: drive inputs, check ready, clock, update model, check outputs.
  task automatic step(input string tag, input bit v, input int ch, input int op,
                      input int d, input bit ordy);
    bit acc;
    ifa.in_valid = v; ifa.in_ch = 2'(ch); ifa.in_op = 2'(op); ifa.in_data = 8'(d);
    ifa.out_ready = ordy;
    ifb.in_valid = v; ifb.in_ch = 2'(ch); ifb.in_op = 2'(op); ifb.in_data = 8'(d);
    ifb.out_ready = ordy;
    #1;
    chk({tag, " wrap in_ready"}, 32'(ifa.in_ready), 32'(!e_valid || ordy));
    chk({tag, " sat in_ready"},  32'(ifb.in_ready), 32'(!e_valid || ordy));
    acc = v && (!e_valid || ordy);
    @(posedge clk);
    #1;
    if (acc) begin
      model_apply(0, ch, op, d);
      model_apply(1, ch, op, d);
      e_valid = 1'b1;
    end else if (ordy) begin
      e_valid = 1'b0;
    end
    check_outputs(tag);
    $display("step %s v=%0b ch=%0d op=%0d d=%02h ordy=%0b acc=%0b | wrap cnt=%02h f=%0b e=%0b | sat cnt=%02h f=%0b e=%0b",
             tag, v, ch, op, d & 255, ordy, acc, ifa.out_count, ifa.out_flag, ifa.out_err,
             ifb.out_count, ifb.out_flag, ifb.out_err);
  endtask

  int r_ch, r_op, r_d, sel;
  bit r_v, r_rdy;

  initial begin
    ifa.in_valid = 0; ifa.in_ch = 0; ifa.in_op = 0; ifa.in_data = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_ch = 0; ifb.in_op = 0; ifb.in_data = 0; ifb.out_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_held");
    rst = 1'b1;
    #1;
    chk("reset wrap in_ready", 32'(ifa.in_ready), 32'd1);
    chk("reset sat in_ready",  32'(ifb.in_ready), 32'd1);

    // LOAD ch2 then three INCs back to back
    step("load_ch2", 1, 2, 0, 8'h10, 1);
    chk("plan first resp", 32'(ifb.out_count), 32'h10);
    step("inc_ch2_a", 1, 2, 1, 0, 1);
    step("inc_ch2_b", 1, 2, 1, 0, 1);
    step("inc_ch2_c", 1, 2, 1, 0, 1);
    chk("plan dout", ifb.dout, 32'h0013_0000);
    chk("plan out_ch", 32'(ifa.out_ch), 32'd2);

    // Upper/lower boundaries on ch0
    step("load_ff", 1, 0, 0, 8'hFF, 1);
    step("inc_ff", 1, 0, 1, 0, 1);
    chk("wrap inc at max", {23'd0, ifa.out_flag, ifa.out_count}, {23'd0, 1'b1, 8'h00});
    chk("sat inc at max",  {23'd0, ifb.out_flag, ifb.out_count}, {23'd0, 1'b1, 8'hFF});
    step("clear0", 1, 0, 3, 0, 1);
    step("dec_zero", 1, 0, 2, 0, 1);
    chk("wrap dec at zero", {23'd0, ifa.out_flag, ifa.out_count}, {23'd0, 1'b1, 8'hFF});
    chk("sat dec at zero",  {23'd0, ifb.out_flag, ifb.out_count}, {23'd0, 1'b1, 8'h00});

    // Backpressure: response held five cycles, then drained with same-cycle accept
    step("bp_accept", 1, 1, 0, 8'h55, 0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1, 1, 1, 0, 0);
    step("bp_drain", 1, 1, 1, 0, 1);
    step("idle", 0, 0, 0, 0, 1);

    // Out-of-range channel on the CH=3 instance
    step("err_ch3", 1, 3, 0, 8'hA5, 1);
    chk("err flag wrap", 32'(ifa.out_err), 32'd1);

    // Randomized traffic with boundary-biased load values
    for (int i = 0; i < 400; i++) begin
      r_v   = ($urandom % 4) != 0;
      r_ch  = int'($urandom % 4);
      r_op  = int'($urandom % 4);
      sel   = int'($urandom % 5);
      r_d   = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 254 : (sel == 3) ? 255
                          : int'($urandom % 256);
      r_rdy = ($urandom % 3) != 0;
      step("rand", r_v, r_ch, r_op, r_d, r_rdy);
    end

    // Asynchronous reset while a response is pending
    step("pre_rst_load", 1, 1, 0, 8'h77, 0);
    chk("pre_rst valid", 32'(ifb.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    ifa.in_valid = 1; ifb.in_valid = 1;
    @(posedge clk);
    #1;
    check_outputs("rst_no_accept");
    rst = 1'b1;
    ifa.in_valid = 0; ifb.in_valid = 0;
    #1;
    chk("post_rst wrap in_ready", 32'(ifa.in_ready), 32'd1);
    step("post_rst_inc", 1, 0, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
